// File: rtl/goertzel_tone_gen.sv
// -----------------------------------------------------------------------------
// goertzel_tone_gen
//
// Digital-resonator tone generator. Produces a bursted sinusoid using the
// second-order recursion y[n] = COEFF*y[n-1] - y[n-2], with COEFF holding
// 2*cos(w) in a signed fixed-point format with COEFF_BITS fractional bits.
// It is the transmit-side counterpart of the Goertzel receive filter and
// shares its coefficient format, so a loopback test can use one COEFF value.
//
// Parameters
//   COEFF       signed 2*cos(w) scaled by 2^COEFF_BITS
//   COEFF_BITS  fractional bits of COEFF
//   INIT        signed seed A*sin(w); also the first emitted sample
//   SAMPLE_DIV  clock cycles per output sample (>= 3)
//   BURST_LEN   samples per burst; 0 = run until stop
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   start         begin a burst (only sampled in IDLE)
//   stop          abort the burst (any state, highest priority)
//   data_o        16-bit signed sample, held between strobes
//   valid_o       one-cycle strobe per new sample
//   done_o        one-cycle pulse on the final sample of a finite burst
//   busy_o        high while the generator is not IDLE
//   sample_cnt_o  samples emitted in the current or most recent burst
//
// Build option
//   GOERTZEL_TONE_SAT_EN  when defined, the 16-bit output saturates to
//                         [-32768, 32767]; otherwise it wraps (low 16 bits).
//                         The internal 32-bit recursion never saturates.
// -----------------------------------------------------------------------------
module goertzel_tone_gen #(
   parameter int          COEFF      = 16384,
   parameter int          COEFF_BITS = 14,
   parameter int          INIT       = 1000,
   parameter int          SAMPLE_DIV = 4,
   parameter int unsigned BURST_LEN  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   output logic signed [15:0] data_o,
   output logic               valid_o,
   output logic               done_o,
   output logic               busy_o,
   output logic [31:0]        sample_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MULT   = 2'd1,
      S_UPDATE = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   // Coefficient widened once so the product is an exact 64-bit signed multiply.
   localparam logic signed [63:0] COEFF_EXT = 64'(COEFF);
   // WAIT lasts SAMPLE_DIV-2 cycles; the divider counts 0 .. SAMPLE_DIV-3.
   localparam logic [31:0]        DIV_LAST  = 32'(SAMPLE_DIV - 3);

   state_t             r_state;
   logic signed [31:0] r_y1;
   logic signed [31:0] r_y2;
   logic signed [31:0] r_prod;
   logic [31:0]        r_div;
   logic [31:0]        r_cnt;
   logic signed [15:0] r_data;
   logic               r_valid;
   logic               r_done;
   logic               r_busy;

   logic signed [63:0] w_y1_ext;
   logic signed [63:0] w_prod_full;
   logic signed [63:0] w_prod_shift;
   logic signed [31:0] w_new;
   logic signed [15:0] w_out16;
   logic [31:0]        w_cnt_inc;
   logic               w_last;
   logic               w_unused_hi;

   // Floor-scaled product: arithmetic shift of the full product, low 32 bits kept.
   assign w_y1_ext     = {{32{r_y1[31]}}, r_y1};
   assign w_prod_full  = w_y1_ext * COEFF_EXT;
   assign w_prod_shift = w_prod_full >>> COEFF_BITS;
   assign w_unused_hi  = &{1'b0, w_prod_shift[63:32]};

   // Recursion step, 32-bit wrapping.
   assign w_new     = r_prod - r_y2;
   assign w_cnt_inc = r_cnt + 32'd1;
   assign w_last    = (BURST_LEN != 32'd0) && (w_cnt_inc == BURST_LEN);

`ifdef GOERTZEL_TONE_SAT_EN
   always_comb begin
      w_out16 = w_new[15:0];
      if (w_new > 32'sd32767) begin
         w_out16 = 16'sh7FFF;
      end else if (w_new < -32'sd32768) begin
         w_out16 = 16'sh8000;
      end
   end
`else
   assign w_out16 = w_new[15:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_y1    <= '0;
         r_y2    <= '0;
         r_prod  <= '0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !stop) begin
                  // Seeding y1=0, y2=-INIT makes the first update emit INIT.
                  r_state <= S_MULT;
                  r_busy  <= 1'b1;
                  r_y1    <= '0;
                  r_y2    <= -32'(INIT);
                  r_cnt   <= '0;
                  r_div   <= '0;
               end
            end
            S_MULT: begin
               if (stop) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_prod  <= w_prod_shift[31:0];
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               if (stop) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_y1    <= w_new;
                  r_y2    <= r_y1;
                  r_data  <= w_out16;
                  r_valid <= 1'b1;
                  r_cnt   <= w_cnt_inc;
                  r_div   <= '0;
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (stop) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_div == DIV_LAST) begin
                  r_state <= S_MULT;
               end else begin
                  r_div <= r_div + 32'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign data_o       = r_data;
   assign valid_o      = r_valid;
   assign done_o       = r_done;
   assign busy_o       = r_busy;
   assign sample_cnt_o = r_cnt;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_goertzel_tone_gen
//
// Directed bench for goertzel_tone_gen. Four generator instances with
// different coefficient/burst settings share one clock and reset; each has
// its own start/stop. Expected sample values and strobe cycles are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_goertzel_tone_gen;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start_a [4];
   logic               stop_a  [4];
   logic signed [15:0] data_a  [4];
   logic               valid_a [4];
   logic               done_a  [4];
   logic               busy_a  [4];
   logic [31:0]        cnt_a   [4];

   int tests = 0;
   int fails = 0;

   int                 st_k    [$];
   logic signed [15:0] st_d    [$];
   logic               st_done [$];
   logic               busy_h  [0:63];

   always #5 clk = ~clk;

   // Instance 0: COEFF=0, period-4 sequence 1000,0,-1000,0,...
   goertzel_tone_gen #(.COEFF(0), .COEFF_BITS(14), .INIT(1000), .SAMPLE_DIV(4), .BURST_LEN(5)) u0 (
      .clk(clk), .rst(rst), .start(start_a[0]), .stop(stop_a[0]),
      .data_o(data_a[0]), .valid_o(valid_a[0]), .done_o(done_a[0]),
      .busy_o(busy_a[0]), .sample_cnt_o(cnt_a[0]));

   // Instance 1: COEFF=1.0, period-6 sequence
   goertzel_tone_gen #(.COEFF(16384), .COEFF_BITS(14), .INIT(1000), .SAMPLE_DIV(4), .BURST_LEN(6)) u1 (
      .clk(clk), .rst(rst), .start(start_a[1]), .stop(stop_a[1]),
      .data_o(data_a[1]), .valid_o(valid_a[1]), .done_o(done_a[1]),
      .busy_o(busy_a[1]), .sample_cnt_o(cnt_a[1]));

   // Instance 2: near-DC coefficient with large seed, overflows 16 bits
   goertzel_tone_gen #(.COEFF(32767), .COEFF_BITS(14), .INIT(20000), .SAMPLE_DIV(4), .BURST_LEN(2)) u2 (
      .clk(clk), .rst(rst), .start(start_a[2]), .stop(stop_a[2]),
      .data_o(data_a[2]), .valid_o(valid_a[2]), .done_o(done_a[2]),
      .busy_o(busy_a[2]), .sample_cnt_o(cnt_a[2]));

   // Instance 3: continuous mode
   goertzel_tone_gen #(.COEFF(16384), .COEFF_BITS(14), .INIT(1000), .SAMPLE_DIV(4), .BURST_LEN(0)) u3 (
      .clk(clk), .rst(rst), .start(start_a[3]), .stop(stop_a[3]),
      .data_o(data_a[3]), .valid_o(valid_a[3]), .done_o(done_a[3]),
      .busy_o(busy_a[3]), .sample_cnt_o(cnt_a[3]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Optionally pulses start (held through edge hold_k), then watches ncyc
   // edges, logging strobes and busy. Edge k is the k-th edge after E0.
   task automatic capture(input int inst, input int ncyc, input bit do_start, input int hold_k);
      st_k.delete();
      st_d.delete();
      st_done.delete();
      if (do_start) begin
         start_a[inst] = 1'b1;
         @(posedge clk);
         if (hold_k == 0) begin
            #1;
            start_a[inst] = 1'b0;
         end
      end
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk);
         #1;
         if (k == hold_k) start_a[inst] = 1'b0;
         busy_h[k] = busy_a[inst];
         if (valid_a[inst]) begin
            st_k.push_back(k);
            st_d.push_back(data_a[inst]);
            st_done.push_back(done_a[inst]);
         end
      end
   endtask

   int exp0 [5] = '{1000, 0, -1000, 0, 1000};
   int exp1 [6] = '{1000, 1000, 0, -1000, -1000, 0};
   int exp2_second;

   initial begin
`ifdef GOERTZEL_TONE_SAT_EN
      exp2_second = 32767;
`else
      exp2_second = -25538;
`endif
      for (int i = 0; i < 4; i++) begin
         start_a[i] = 1'b0;
         stop_a[i]  = 1'b0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_data",  32'(data_a[0]),  32'd0);
      check("rst_valid", 32'(valid_a[0]), 32'd0);
      check("rst_done",  32'(done_a[0]),  32'd0);
      check("rst_busy",  32'(busy_a[0]),  32'd0);
      check("rst_cnt",   cnt_a[0],        32'd0);
      $display("[TB] reset state checked");

      // Finite burst, COEFF=0
      capture(0, 18, 1'b1, 0);
      check("b0_nstrobe", 32'(st_k.size()), 32'd5);
      for (int i = 0; i < 5 && i < st_k.size(); i++) begin
         check($sformatf("b0_k%0d", i),    32'(st_k[i]),    32'(2 + 4 * i));
         check($sformatf("b0_d%0d", i),    32'(st_d[i]),    32'(exp0[i]));
         check($sformatf("b0_done%0d", i), 32'(st_done[i]), (i == 4) ? 32'd1 : 32'd0);
      end
      check("b0_cnt",     cnt_a[0],        32'd5);
      check("b0_busy17",  32'(busy_h[17]), 32'd1);
      check("b0_busy18",  32'(busy_h[18]), 32'd0);
      $display("[TB] burst COEFF=0: %0d strobes", st_k.size());

      // Restart immediately after done
      capture(0, 2, 1'b1, 0);
      check("re_nstrobe", 32'(st_k.size()), 32'd1);
      if (st_k.size() > 0) begin
         check("re_k0", 32'(st_k[0]), 32'd2);
         check("re_d0", 32'(st_d[0]), 32'd1000);
      end
      capture(0, 20, 1'b0, 0);
      check("re_rest", 32'(st_k.size()), 32'd4);
      check("re_cnt",  cnt_a[0],         32'd5);
      $display("[TB] restart after done checked");

      // start held high mid-burst is ignored
      capture(0, 20, 1'b1, 9);
      check("hold_nstrobe", 32'(st_k.size()), 32'd5);
      for (int i = 0; i < 5 && i < st_k.size(); i++) begin
         check($sformatf("hold_k%0d", i), 32'(st_k[i]), 32'(2 + 4 * i));
         check($sformatf("hold_d%0d", i), 32'(st_d[i]), 32'(exp0[i]));
      end
      check("hold_cnt", cnt_a[0], 32'd5);
      $display("[TB] held start checked");

      // COEFF=1.0 burst of 6
      capture(1, 24, 1'b1, 0);
      check("b1_nstrobe", 32'(st_k.size()), 32'd6);
      for (int i = 0; i < 6 && i < st_k.size(); i++) begin
         check($sformatf("b1_k%0d", i), 32'(st_k[i]), 32'(2 + 4 * i));
         check($sformatf("b1_d%0d", i), 32'(st_d[i]), 32'(exp1[i]));
      end
      if (st_done.size() == 6) check("b1_done5", 32'(st_done[5]), 32'd1);
      check("b1_busy21", 32'(busy_h[21]), 32'd1);
      check("b1_busy22", 32'(busy_h[22]), 32'd0);
      check("b1_cnt",    cnt_a[1],        32'd6);
      $display("[TB] burst COEFF=16384: %0d strobes", st_k.size());

      // Output overflow: saturate or wrap
      capture(2, 8, 1'b1, 0);
      check("b2_nstrobe", 32'(st_k.size()), 32'd2);
      if (st_k.size() == 2) begin
         check("b2_d0", 32'(st_d[0]), 32'd20000);
         check("b2_d1", 32'(st_d[1]), 32'(exp2_second));
      end
      $display("[TB] overflow burst checked");

      // Continuous mode, stop in WAIT after 3 samples
      capture(3, 11, 1'b1, 0);
      check("c_nstrobe", 32'(st_k.size()), 32'd3);
      for (int i = 0; i < st_done.size(); i++)
         check($sformatf("c_done%0d", i), 32'(st_done[i]), 32'd0);
      stop_a[3] = 1'b1;
      @(posedge clk);
      #1;
      stop_a[3] = 1'b0;
      check("c_busy",  32'(busy_a[3]),  32'd0);
      check("c_valid", 32'(valid_a[3]), 32'd0);
      check("c_done",  32'(done_a[3]),  32'd0);
      check("c_cnt",   cnt_a[3],        32'd3);
      capture(3, 20, 1'b0, 0);
      check("c_after", 32'(st_k.size()), 32'd0);
      check("c_cnt2",  cnt_a[3],         32'd3);
      $display("[TB] stop in continuous mode checked");

      // start and stop together in IDLE
      start_a[0] = 1'b1;
      stop_a[0]  = 1'b1;
      @(posedge clk);
      #1;
      start_a[0] = 1'b0;
      stop_a[0]  = 1'b0;
      check("ss_busy", 32'(busy_a[0]), 32'd0);
      capture(0, 8, 1'b0, 0);
      check("ss_nstrobe", 32'(st_k.size()), 32'd0);
      $display("[TB] start+stop in IDLE checked");

      // Asynchronous reset while in MULT
      start_a[0] = 1'b1;
      @(posedge clk);
      #1;
      start_a[0] = 1'b0;
      check("rm_busy_pre", 32'(busy_a[0]), 32'd1);
      check("rm_data_pre", 32'(data_a[0]), 32'd1000);
      rst = 1'b1;
      #1;
      check("rm_data",  32'(data_a[0]),  32'd0);
      check("rm_valid", 32'(valid_a[0]), 32'd0);
      check("rm_done",  32'(done_a[0]),  32'd0);
      check("rm_busy",  32'(busy_a[0]),  32'd0);
      check("rm_cnt",   cnt_a[0],        32'd0);
      @(negedge clk);
      rst = 1'b0;
      capture(0, 20, 1'b1, 0);
      check("rm_after", 32'(st_k.size()), 32'd5);
      $display("[TB] reset during MULT checked");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
